// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN sequencer: default sizes, opcodes and FSM state encoding.
package rpn_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH   = 3'd1,
    S_POP_B  = 3'd2,
    S_POP_A  = 3'd3,
    S_CAPT_A = 3'd4,
    S_WRITE  = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  function automatic logic is_binop(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/rpn_sequencer_if.sv
// Command and stack-side signal bundle; slave is the sequencer, master is the host plus stack.
interface rpn_sequencer_if #(
  parameter int WIDTH = rpn_pkg::DEF_WIDTH
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             error;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_data_in;
  logic [WIDTH-1:0] stk_data_out;
  logic             stk_empty;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, stk_data_out, stk_empty,
    output cmd_ready, result, result_valid, error, stk_push, stk_pop, stk_data_in
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, stk_data_out, stk_empty,
    input  cmd_ready, result, result_valid, error, stk_push, stk_pop, stk_data_in
  );

endinterface

// File: rtl/rpn_alu.sv
// Combinational operator for the sequencer; modulo 2^WIDTH, reserved opcodes yield zero.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Operator select
  always_comb begin
    y = {WIDTH{1'b0}};
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// RPN command sequencer: pushes immediates and evaluates binary ops on an external
// stack with registered pop data, tracking stack depth internally.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic             clk,
  input logic             reset,
  rpn_sequencer_if.slave  bus
);

  localparam int             DW         = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0]  DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0]  DEPTH_ONE  = DW'(1);
  localparam logic [DW-1:0]  DEPTH_TWO  = DW'(2);

  state_t           state_r;
  logic [DW-1:0]    depth_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] stk_data_in_r;
  logic             cmd_ready_r;
  logic             result_valid_r;
  logic             error_r;
  logic             stk_push_r;
  logic             stk_pop_r;
  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_y_s;

  // A is forwarded straight from the stack in CAPT_A so the write-back value can be registered
  always_comb begin
    if (state_r == S_CAPT_A) begin
      alu_a_s = bus.stk_data_out;
    end else begin
      alu_a_s = a_r;
    end
  end

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_r),
    .a  (alu_a_s),
    .b  (b_r),
    .y  (alu_y_s)
  );

  // Sequencer FSM with registered strobes and result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      depth_r        <= {DW{1'b0}};
      op_r           <= OP_PUSH;
      a_r            <= {WIDTH{1'b0}};
      b_r            <= {WIDTH{1'b0}};
      result_r       <= {WIDTH{1'b0}};
      stk_data_in_r  <= {WIDTH{1'b0}};
      cmd_ready_r    <= 1'b1;
      result_valid_r <= 1'b0;
      error_r        <= 1'b0;
      stk_push_r     <= 1'b0;
      stk_pop_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready_r <= 1'b0;
            op_r        <= bus.cmd_op;
            if (bus.cmd_op == OP_PUSH) begin
              if (depth_r < DEPTH_FULL) begin
                state_r       <= S_PUSH;
                stk_push_r    <= 1'b1;
                stk_data_in_r <= bus.cmd_data;
                depth_r       <= depth_r + DEPTH_ONE;
              end else begin
                state_r <= S_ERR;
                error_r <= 1'b1;
              end
            end else if (is_binop(bus.cmd_op)) begin
              if (depth_r >= DEPTH_TWO) begin
                state_r   <= S_POP_B;
                stk_pop_r <= 1'b1;
              end else begin
                state_r <= S_ERR;
                error_r <= 1'b1;
              end
            end else begin
              state_r <= S_ERR;
              error_r <= 1'b1;
            end
          end
        end
        S_PUSH: begin
          stk_push_r  <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
        S_POP_B: begin
          state_r <= S_POP_A;
        end
        // First pop's data (B, the newer entry) is visible while the second pop is issued
        S_POP_A: begin
          stk_pop_r <= 1'b0;
          b_r       <= bus.stk_data_out;
          state_r   <= S_CAPT_A;
        end
        S_CAPT_A: begin
          a_r            <= bus.stk_data_out;
          stk_push_r     <= 1'b1;
          stk_data_in_r  <= alu_y_s;
          result_r       <= alu_y_s;
          result_valid_r <= 1'b1;
          depth_r        <= depth_r - DEPTH_ONE;
          state_r        <= S_WRITE;
        end
        S_WRITE: begin
          stk_push_r     <= 1'b0;
          result_valid_r <= 1'b0;
          cmd_ready_r    <= 1'b1;
          state_r        <= S_IDLE;
        end
        S_ERR: begin
          error_r     <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
        default: begin
          stk_push_r     <= 1'b0;
          stk_pop_r      <= 1'b0;
          result_valid_r <= 1'b0;
          error_r        <= 1'b0;
          cmd_ready_r    <= 1'b1;
          state_r        <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_r;
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.error        = error_r;
  assign bus.stk_push     = stk_push_r;
  assign bus.stk_pop      = stk_pop_r;
  assign bus.stk_data_in  = stk_data_in_r;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer with a behavioural registered-pop stack attached.
module tb_rpn_sequencer;
  import rpn_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   viol;

  rpn_sequencer_if #(.WIDTH(WIDTH)) bus ();

  rpn_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack model: registered pop data, cleared by the same reset
  logic [WIDTH-1:0] mem [0:15];
  int               sp;
  logic [WIDTH-1:0] pop_q;

  always @(posedge clk) begin
    if (reset) begin
      sp    <= 0;
      pop_q <= 8'h00;
    end else if (bus.stk_push) begin
      mem[sp] <= bus.stk_data_in;
      sp      <= sp + 1;
    end else if (bus.stk_pop) begin
      pop_q <= mem[sp - 1];
      sp    <= sp - 1;
    end
  end

  assign bus.stk_data_out = pop_q;
  assign bus.stk_empty    = (sp == 0);

  // Strobe exclusivity and ready/state consistency
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.stk_push && bus.stk_pop) viol++;
      if ((dut.state_r == S_IDLE || dut.state_r == S_ERR) && (bus.stk_push || bus.stk_pop)) viol++;
      if (bus.cmd_ready != (dut.state_r == S_IDLE)) viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [4:0]       pop_m, push_m, rv_m, err_m;
  logic [WIDTH-1:0] wdata;
  logic             ready_end;

  task automatic do_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Issue one command and record strobes over cycles N+1..N+5 (bit k = cycle N+1+k)
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    pop_m = 5'b0; push_m = 5'b0; rv_m = 5'b0; err_m = 5'b0; wdata = 8'h00;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      pop_m[k]  = bus.stk_pop;
      push_m[k] = bus.stk_push;
      rv_m[k]   = bus.result_valid;
      err_m[k]  = bus.error;
      if (bus.stk_push) wdata = bus.stk_data_in;
    end
    ready_end = bus.cmd_ready;
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  logic [2:0]       seq_op   [5];
  logic [WIDTH-1:0] seq_data [5];
  int               idx, n_push, n_pop, n_rv, n_err;
  logic             last_ready;

  initial begin
    n_checks = 0; n_fail = 0; viol = 0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'b000; bus.cmd_data = 8'h00;
    reset = 1'b1;

    vecs[0] = '{OP_SUB, 8'h05, 8'h03, 8'h02};
    vecs[1] = '{OP_ADD, 8'hF0, 8'h20, 8'h10};
    vecs[2] = '{OP_AND, 8'hCC, 8'hAA, 8'h88};
    vecs[3] = '{OP_OR,  8'hCC, 8'hAA, 8'hEE};
    vecs[4] = '{OP_XOR, 8'hCC, 8'hAA, 8'h66};
    vecs[5] = '{OP_SUB, 8'h03, 8'h05, 8'hFE};
    vecs[6] = '{OP_ADD, 8'hFF, 8'h01, 8'h00};

    repeat (2) @(posedge clk);
    do_reset();
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_strobes", {28'd0, bus.stk_push, bus.stk_pop, bus.result_valid, bus.error}, 32'd0);
    chk("rst_depth", 32'(dut.depth_r), 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      issue(OP_PUSH, vecs[i].a);
      chk($sformatf("v%0d_pushA", i), {27'd0, push_m}, 32'b00001);
      issue(OP_PUSH, vecs[i].b);
      chk($sformatf("v%0d_pushB_data", i), 32'(wdata), 32'(vecs[i].b));
      issue(vecs[i].op, 8'h00);
      chk($sformatf("v%0d_pop", i), {27'd0, pop_m}, 32'b00011);
      chk($sformatf("v%0d_push", i), {27'd0, push_m}, 32'b01000);
      chk($sformatf("v%0d_rv", i), {27'd0, rv_m}, 32'b01000);
      chk($sformatf("v%0d_err", i), {27'd0, err_m}, 32'b00000);
      chk($sformatf("v%0d_wdata", i), 32'(wdata), 32'(vecs[i].exp));
      chk($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].exp));
      chk($sformatf("v%0d_depth", i), 32'(dut.depth_r), 32'd1);
      chk($sformatf("v%0d_stack_top", i), 32'(mem[0]), 32'(vecs[i].exp));
      chk($sformatf("v%0d_ready", i), 32'(ready_end), 32'd1);
    end

    // Rejected command must not disturb the held result
    issue(3'b110, 8'h00);
    chk("hold_err", {27'd0, err_m}, 32'b00001);
    chk("hold_result", 32'(bus.result), 32'h00);
    chk("hold_depth", 32'(dut.depth_r), 32'd1);

    // Overflow: ninth push rejected
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(OP_PUSH, 8'(i + 1));
      chk($sformatf("fill%0d_push", i), {27'd0, push_m | err_m}, 32'b00001);
    end
    issue(OP_PUSH, 8'h99);
    chk("ovf_err", {27'd0, err_m}, 32'b00001);
    chk("ovf_push", {27'd0, push_m}, 32'b00000);
    chk("ovf_depth", 32'(dut.depth_r), 32'd8);
    chk("ovf_model_sp", 32'(sp), 32'd8);

    // Underflow and reserved opcodes
    do_reset();
    issue(OP_PUSH, 8'h07);
    issue(OP_ADD, 8'h00);
    chk("unf_err", {27'd0, err_m}, 32'b00001);
    chk("unf_pop", {27'd0, pop_m}, 32'b00000);
    chk("unf_depth", 32'(dut.depth_r), 32'd1);
    chk("unf_result", 32'(bus.result), 32'h00);
    issue(3'b111, 8'h00);
    chk("rsv7_err", {27'd0, err_m | push_m | pop_m}, 32'b00001);
    chk("rsv7_depth", 32'(dut.depth_r), 32'd1);

    // Reset while in POP_A aborts the op
    do_reset();
    issue(OP_PUSH, 8'h01);
    issue(OP_PUSH, 8'h02);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_popa", 32'(dut.state_r), 32'(S_POP_A));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_state", 32'(dut.state_r), 32'(S_IDLE));
    chk("abort_strobes", {28'd0, bus.stk_push, bus.stk_pop, bus.result_valid, bus.error}, 32'd0);
    chk("abort_depth", 32'(dut.depth_r), 32'd0);
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    n_push = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.stk_push || bus.stk_pop || bus.result_valid) n_push++;
    end
    chk("abort_quiet", 32'(n_push), 32'd0);

    // cmd_valid held high: each command accepted exactly once
    do_reset();
    seq_op[0] = OP_PUSH; seq_data[0] = 8'h10;
    seq_op[1] = OP_PUSH; seq_data[1] = 8'h20;
    seq_op[2] = OP_PUSH; seq_data[2] = 8'h30;
    seq_op[3] = OP_ADD;  seq_data[3] = 8'h00;
    seq_op[4] = OP_SUB;  seq_data[4] = 8'h00;
    idx = 0; n_push = 0; n_pop = 0; n_rv = 0; n_err = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = seq_op[0]; bus.cmd_data = seq_data[0];
    last_ready = bus.cmd_ready;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.cmd_valid && last_ready) idx++;
      if (idx >= 5) begin
        bus.cmd_valid = 1'b0;
      end else begin
        bus.cmd_op = seq_op[idx]; bus.cmd_data = seq_data[idx];
      end
      n_push += int'(bus.stk_push);
      n_pop  += int'(bus.stk_pop);
      n_rv   += int'(bus.result_valid);
      n_err  += int'(bus.error);
      last_ready = bus.cmd_ready;
    end
    chk("held_accepted", 32'(idx), 32'd5);
    chk("held_push_cnt", 32'(n_push), 32'd5);
    chk("held_pop_cnt", 32'(n_pop), 32'd4);
    chk("held_rv_cnt", 32'(n_rv), 32'd2);
    chk("held_err_cnt", 32'(n_err), 32'd0);
    chk("held_result", 32'(bus.result), 32'hC0);
    chk("held_depth", 32'(dut.depth_r), 32'd1);

    chk("protocol_violations", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rpn_sequencer.md
RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, data width of operands and stack entries.
REQ-002 Parameter DEPTH, default 8, capacity of the attached stack; the depth counter is $clog2(DEPTH)+1 bits.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-007 cmd_op  in  3  opcode: 000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110/111 reserved.
REQ-008 cmd_data  in  WIDTH  immediate operand, used by PUSH only.
REQ-009 result  out  WIDTH  last computed value.
REQ-010 result_valid  out  1  one-cycle pulse; result is new.
REQ-011 error  out  1  one-cycle pulse; command rejected.
REQ-012 stk_push  out  1  push strobe to the stack.
REQ-013 stk_pop  out  1  pop strobe to the stack.
REQ-014 stk_data_in  out  WIDTH  value to push.
REQ-015 stk_data_out  in  WIDTH  stack registered pop data, valid the cycle after stk_pop.
REQ-016 stk_empty  in  1  stack empty flag, informational only.

Function
REQ-017 The FSM SHALL have states IDLE, PUSH, POP_B, POP_A, CAPT_A, WRITE and ERR.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clk edge with cmd_valid && cmd_ready.
REQ-019 PUSH accepted with depth < DEPTH: go to PUSH, drive stk_push=1 and stk_data_in=cmd_data for exactly one cycle, increment depth, return to IDLE.
REQ-020 Binary op accepted with depth >= 2: go to POP_B and assert stk_pop.
REQ-021 From POP_B, go to POP_A, capture stk_data_out as B, and assert stk_pop again.
REQ-022 From POP_A, go to CAPT_A and capture stk_data_out as A.
REQ-023 In WRITE, drive stk_push=1 and stk_data_in=op(A,B), load result, pulse result_valid, then return to IDLE; net depth change is -1.
REQ-024 Latency SHALL be: binary op accepted at edge N gives stk_pop high in cycles N+1 and N+2, stk_push and result_valid high in cycle N+4; PUSH accepted at edge N gives stk_push in cycle N+1.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH with no carry or borrow output; SUB = A - B, where A is the older entry.
REQ-026 Any of the following SHALL go to ERR, pulse error for one cycle with no stack strobe, leave depth unchanged, and return to IDLE: PUSH at depth == DEPTH, binary op at depth < 2, reserved opcode.
REQ-027 stk_push and stk_pop SHALL never be high in the same cycle, and neither is high in IDLE or ERR.
REQ-028 result SHALL hold its value between result_valid pulses.

Reset
REQ-029 On reset: state IDLE, depth 0, A, B and result 0, result_valid, error, stk_push and stk_pop 0, cmd_ready 1 in the following cycle.
REQ-030 Reset in any state SHALL abort the operation with no further strobes; the same reset SHALL drive the attached stack so that depth 0 matches an empty stack.

Structure
REQ-031 The opcode constants, the FSM state encoding and the default WIDTH/DEPTH SHALL live in shared package rpn_pkg.
REQ-032 The op(A,B) function SHALL be a combinational sub-module rpn_alu (inputs op, a, b; output y), instantiated once.
REQ-033 The depth counter SHALL be internal and SHALL NOT be inferred from stk_empty.

Verification
REQ-034 Reset, then PUSH 0x05, then PUSH 0x03, then SUB -> stk_pop in cycles N+1 and N+2, stk_push with 0x02 and result=0x02 with result_valid in cycle N+4, depth 1.
REQ-035 PUSH 0xF0, PUSH 0x20, ADD -> result 0x10 (wrap), no other flag.
REQ-036 9 consecutive PUSHes at DEPTH=8 -> the ninth gives error pulse and no stk_push; depth stays 8.
REQ-037 ADD with depth 1 -> error pulse, no stk_pop, depth 1; opcode 111 -> error pulse.
REQ-038 Reset asserted in POP_A -> next cycle IDLE, all strobes 0, depth 0, cmd_ready 1.
REQ-039 cmd_valid held high continuously -> cmd_ready low throughout each op; commands are accepted only in IDLE, with no command lost or duplicated.
